// File: rtl/corr_seq_tx.sv
// Chip-sequence transmitter: preamble of CODE frames, then payload bits spread as CODE / ~CODE.
// Optional payload scrambler enabled by defining SEQ_TX_SCRAMBLE_EN.
module corr_seq_tx #(
    parameter int unsigned              CODE_W    = 3,
    parameter logic [CODE_W-1:0]        CODE      = 3'b101,
    parameter int unsigned              PRE_LEN   = 4,
    parameter int unsigned              DATA_W    = 8,
    parameter int unsigned              FRAME_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [CODE_W-1:0] chip_out,
    output logic [CODE_W-1:0] ref_out,
    output logic              frame_stb,
    output logic              sync,
    output logic              busy
);

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned PRE_W = (PRE_LEN   > 1) ? $clog2(PRE_LEN)   : 1;
    localparam int unsigned BIT_W = (DATA_W    > 1) ? $clog2(DATA_W)    : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [PRE_W-1:0]  pre_q,   pre_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CODE_W-1:0] chip_q,  chip_d;
    logic              stb_q,   stb_d;
    logic              sync_q,  sync_d;
    logic              busy_q,  busy_d;
    logic              ready_q, ready_d;
`ifdef SEQ_TX_SCRAMBLE_EN
    logic [6:0]        lfsr_q,  lfsr_d;
`endif

    logic frame_end;
    logic tx_bit;

    assign frame_end = (div_q == DIV_W'(FRAME_DIV - 1));

`ifdef SEQ_TX_SCRAMBLE_EN
    assign tx_bit = data_q[DATA_W-1] ^ lfsr_q[6];
`else
    assign tx_bit = data_q[DATA_W-1];
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pre_d   = pre_q;
        bit_d   = bit_q;
        data_d  = data_q;
        chip_d  = chip_q;
        stb_d   = 1'b0;
        sync_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
`ifdef SEQ_TX_SCRAMBLE_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (data_valid && ready_q) begin
                    state_d = ST_PRE;
                    data_d  = data_in;
                    div_d   = '0;
                    pre_d   = '0;
                    bit_d   = '0;
                    chip_d  = CODE;
                    stb_d   = 1'b1;
                    sync_d  = 1'b1;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
`ifdef SEQ_TX_SCRAMBLE_EN
                    lfsr_d  = 7'h7F;
`endif
                end
            end
            ST_PRE: begin
                if (frame_end) begin
                    div_d = '0;
                    stb_d = 1'b1;
                    // Last preamble frame hands straight over to the first payload bit.
                    if (pre_q == PRE_W'(PRE_LEN - 1)) begin
                        state_d = ST_PAY;
                        bit_d   = '0;
                        chip_d  = tx_bit ? CODE : ~CODE;
                        data_d  = data_q << 1;
`ifdef SEQ_TX_SCRAMBLE_EN
                        lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_PAY: begin
                if (frame_end) begin
                    div_d = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = ST_IDLE;
                        chip_d  = '0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        stb_d   = 1'b1;
                        chip_d  = tx_bit ? CODE : ~CODE;
                        data_d  = data_q << 1;
`ifdef SEQ_TX_SCRAMBLE_EN
                        lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                chip_d  = '0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            pre_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            chip_q  <= '0;
            stb_q   <= 1'b0;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SEQ_TX_SCRAMBLE_EN
            lfsr_q  <= 7'h7F;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            chip_q  <= chip_d;
            stb_q   <= stb_d;
            sync_q  <= sync_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef SEQ_TX_SCRAMBLE_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign data_ready = ready_q;
    assign chip_out   = chip_q;
    assign ref_out    = CODE;
    assign frame_stb  = stb_q;
    assign sync       = sync_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_corr_seq_tx.sv
// Scoreboard bench for corr_seq_tx: one instance with FRAME_DIV=1, one with FRAME_DIV=3.
module tb_corr_seq_tx;

    localparam logic [2:0] CODE = 3'b101;

    typedef struct packed {
        logic [2:0] chip;
        logic       sync;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, dv0, ready0, stb0, sync0, busy0;
    logic [7:0] din0;
    logic [2:0] chip0, ref0;
    logic       rst_n1, dv1, ready1, stb1, sync1, busy1;
    logic [7:0] din1;
    logic [2:0] chip1, ref1;

    corr_seq_tx #(.CODE_W(3), .CODE(CODE), .PRE_LEN(4), .DATA_W(8), .FRAME_DIV(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .data_in(din0), .data_valid(dv0), .data_ready(ready0),
        .chip_out(chip0), .ref_out(ref0), .frame_stb(stb0), .sync(sync0), .busy(busy0));

    corr_seq_tx #(.CODE_W(3), .CODE(CODE), .PRE_LEN(4), .DATA_W(8), .FRAME_DIV(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .data_in(din1), .data_valid(dv1), .data_ready(ready1),
        .chip_out(chip1), .ref_out(ref1), .frame_stb(stb1), .sync(sync1), .busy(busy1));

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   mon_en = 1'b0;
    int   run_len[2];
    bit   prev_busy[2];
    logic [2:0] prev_chip[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected frame list for one packet, derived from the payload word.
    task automatic push_pkt(input int d, input logic [7:0] data);
        logic [6:0] s;
        logic       b;
        exp_t       e;
        s = 7'h7F;
        for (int i = 0; i < 4; i++) begin
            e.chip = CODE;
            e.sync = (i == 0);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            b = data[i];
`ifdef SEQ_TX_SCRAMBLE_EN
            b = b ^ s[6];
            s = {s[5:0], s[6] ^ s[5]};
`endif
            e.chip = b ? CODE : ~CODE;
            e.sync = 1'b0;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic mon(input int d, input int div, input logic rst, input logic busy,
                       input logic stb, input logic syn, input logic rdy, input logic [2:0] chip);
        exp_t e;
        int   qs;
        if (!rst || !mon_en) begin
            run_len[d]   = 0;
            prev_busy[d] = 1'b0;
            return;
        end
        qs = (d == 0) ? q0.size() : q1.size();
        if (busy) begin
            run_len[d]++;
            chk($sformatf("d%0d_stb_phase", d), stb, ((run_len[d] - 1) % div) == 0);
            chk($sformatf("d%0d_ready_busy", d), rdy, 0);
            if (stb) begin
                if (qs == 0) begin
                    chk($sformatf("d%0d_unexpected_frame", d), stb, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("d%0d_frame_chip", d), chip, e.chip);
                    chk($sformatf("d%0d_frame_sync", d), syn, e.sync);
                end
            end else begin
                chk($sformatf("d%0d_chip_hold", d), chip, prev_chip[d]);
                chk($sformatf("d%0d_sync_off", d), syn, 0);
            end
            prev_chip[d] = chip;
        end else begin
            if (prev_busy[d]) begin
                chk($sformatf("d%0d_busy_len", d), run_len[d], 12 * div);
                run_len[d] = 0;
            end
            chk($sformatf("d%0d_idle_chip", d), chip, 0);
            chk($sformatf("d%0d_idle_stb", d), stb, 0);
            chk($sformatf("d%0d_idle_sync", d), syn, 0);
            chk($sformatf("d%0d_idle_ready", d), rdy, 1);
        end
        prev_busy[d] = busy;
    endtask

    always @(negedge clk) begin
        mon(0, 1, rst_n0, busy0, stb0, sync0, ready0, chip0);
        mon(1, 3, rst_n1, busy1, stb1, sync1, ready1, chip1);
    end

    task automatic send(input int d, input logic [7:0] data, input bit keep);
        int n = 0;
        while (((d == 0) ? ready0 : ready1) !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("send_ready_timeout", n < 200, 1);
        if (d == 0) begin din0 = data; dv0 = 1'b1; end
        else        begin din1 = data; dv1 = 1'b1; end
        push_pkt(d, data);
        @(posedge clk); #1;
        if (!keep) begin
            if (d == 0) dv0 = 1'b0; else dv1 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (((d == 0) ? busy0 : busy1) !== 1'b0 && n < 400);
        chk("idle_timeout", n < 400, 1);
    endtask

    initial begin
        int n;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        dv0 = 1'b0; dv1 = 1'b1;
        din0 = '0; din1 = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chip0", chip0, 0);   chk("rst_stb0", stb0, 0);   chk("rst_sync0", sync0, 0);
        chk("rst_busy0", busy0, 0);   chk("rst_ready0", ready0, 1); chk("rst_ref0", ref0, 3'b101);
        chk("rst_chip1", chip1, 0);   chk("rst_busy1", busy1, 0);   chk("rst_ready1", ready1, 1);
        chk("rst_ref1", ref1, 3'b101);
        dv1 = 1'b0;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Basic packet
        send(0, 8'hA5, 1'b0);
        chk("a5_first_sync", sync0, 1);
        wait_idle(0);
        chk("a5_end_chip", chip0, 0);
        chk("a5_end_ready", ready0, 1);

        // Divided frame rate
        send(1, 8'h80, 1'b0);
        wait_idle(1);

        // Back-to-back with valid held, data_in changing mid-packet
        send(0, 8'hFF, 1'b1);
        din0 = 8'h00;
        push_pkt(0, 8'h00);
        n = 0;
        while (busy0 !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("b2b_idle_timeout", n < 100, 1);
        chk("b2b_gap_chip", chip0, 0);
        chk("b2b_gap_ready", ready0, 1);
        @(posedge clk); #1;
        chk("b2b_restart_busy", busy0, 1);
        chk("b2b_restart_sync", sync0, 1);
        dv0 = 1'b0;
        wait_idle(0);

        // Reset during payload frame 3
        send(0, 8'hA5, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_chip_before_rst", chip0, 3'b101);
        rst_n0 = 1'b0; dv0 = 1'b1; din0 = 8'h3C;
        @(posedge clk); #1;
        q0.delete();
        chk("mid_rst_chip", chip0, 0);  chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_stb", stb0, 0);    chk("mid_rst_sync", sync0, 0);
        chk("mid_rst_ready", ready0, 1);
        @(posedge clk); #1;
        chk("rst_ignores_valid", busy0, 0);
        dv0 = 1'b0; rst_n0 = 1'b1;
        @(posedge clk); #1;
        send(0, 8'h3C, 1'b0);
        chk("after_rst_sync", sync0, 1);
        wait_idle(0);

        // Two zero packets (exercise scrambler reseed when enabled)
        send(0, 8'h00, 1'b0);
        wait_idle(0);
        send(0, 8'h00, 1'b0);
        wait_idle(0);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
